// File: rtl/fpu_pkg.sv
// Shared types for the FP issue/completion scheduler.
//   fpu_op_t     : request opcode, also the index of the execution slot
//   slot_state_t : per-unit slot life cycle
//   rr_pick      : round-robin selector used by the result arbiter
package fpu_pkg;

    localparam int NUM_UNITS = 4;

    typedef enum logic [1:0] {
        FADD = 2'd0,
        FSUB = 2'd1,
        FMUL = 2'd2,
        FDIV = 2'd3
    } fpu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } slot_state_t;

    // First set bit of req at or after ptr, wrapping. Walking from the far end
    // back toward ptr lets the nearest candidate overwrite the others.
    function automatic logic [1:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                           input logic [1:0]           ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/fpu_slot.sv
// One execution slot in front of an AXI4-Stream FP core.
// Holds the operands and destination tag of a single in-flight operation,
// drives the core's a/b channels, captures the result and parks it until
// the output arbiter grants it.
//   accept/op_a/op_b/op_rd : new operation (only asserted while IDLE)
//   grant                  : arbiter takes the parked result this cycle
//   state/slot_rd/slot_result : slot status, tag and result buffer
//   axis_a_*/axis_b_*      : operand channels to the core
//   axis_result_*          : result channel from the core
module fpu_slot
    import fpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              accept,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [TAG_W-1:0]  op_rd,
    input  logic              grant,
    output slot_state_t       state,
    output logic [TAG_W-1:0]  slot_rd,
    output logic [DATA_W-1:0] slot_result,
    output logic [DATA_W-1:0] axis_a_tdata,
    output logic              axis_a_tvalid,
    input  logic              axis_a_tready,
    output logic [DATA_W-1:0] axis_b_tdata,
    output logic              axis_b_tvalid,
    input  logic              axis_b_tready,
    input  logic [DATA_W-1:0] axis_result_tdata,
    input  logic              axis_result_tvalid,
    output logic              axis_result_tready
);

    slot_state_t       state_nxt;
    logic              a_vld;
    logic              b_vld;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [TAG_W-1:0]  rd_q;
    logic [DATA_W-1:0] res_q;
    logic              take;

    assign take          = (state == IDLE) && accept;
    assign axis_a_tdata  = a_q;
    assign axis_b_tdata  = b_q;
    assign axis_a_tvalid = a_vld;
    assign axis_b_tvalid = b_vld;
    assign slot_rd       = rd_q;
    assign slot_result   = res_q;

    always_comb begin
        state_nxt          = state;
        axis_result_tready = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            // Leave ISSUE in the cycle the last outstanding operand handshakes.
            ISSUE: if ((!a_vld || axis_a_tready) && (!b_vld || axis_b_tready))
                       state_nxt = WAIT;
            WAIT: begin
                axis_result_tready = 1'b1;
                if (axis_result_tvalid) state_nxt = DONE;
            end
            DONE:  if (grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            a_vld <= 1'b0;
            b_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take)                              a_vld <= 1'b1;
            else if (a_vld && axis_a_tready)       a_vld <= 1'b0;
            if (take)                              b_vld <= 1'b1;
            else if (b_vld && axis_b_tready)       b_vld <= 1'b0;
        end
    end

    // Payload registers carry no reset; they are qualified by the state.
    always_ff @(posedge clk) begin
        if (take) begin
            a_q  <= op_a;
            b_q  <= op_b;
            rd_q <= op_rd;
        end
        if ((state == WAIT) && axis_result_tvalid)
            res_q <= axis_result_tdata;
    end

endmodule

// File: rtl/fpu_sched.sv
// Issue/completion scheduler between the CPU core and four AXI4-Stream FP
// cores (fadd, fsub, fmul, fdiv).
//   req_*      : operation request handshake (op, operands, destination tag)
//   res_*      : result handshake back to the core, with destination tag
//   pending    : bit i set while a result for register i is outstanding
//   <u>_axis_* : operand and result channels of each FP core
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_rd,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [TAG_W-1:0]  res_rd,
    output logic [31:0]       pending,
    output logic [DATA_W-1:0] fadd_axis_a_tdata,
    output logic              fadd_axis_a_tvalid,
    input  logic              fadd_axis_a_tready,
    output logic [DATA_W-1:0] fadd_axis_b_tdata,
    output logic              fadd_axis_b_tvalid,
    input  logic              fadd_axis_b_tready,
    input  logic [DATA_W-1:0] fadd_axis_result_tdata,
    input  logic              fadd_axis_result_tvalid,
    output logic              fadd_axis_result_tready,
    output logic [DATA_W-1:0] fsub_axis_a_tdata,
    output logic              fsub_axis_a_tvalid,
    input  logic              fsub_axis_a_tready,
    output logic [DATA_W-1:0] fsub_axis_b_tdata,
    output logic              fsub_axis_b_tvalid,
    input  logic              fsub_axis_b_tready,
    input  logic [DATA_W-1:0] fsub_axis_result_tdata,
    input  logic              fsub_axis_result_tvalid,
    output logic              fsub_axis_result_tready,
    output logic [DATA_W-1:0] fmul_axis_a_tdata,
    output logic              fmul_axis_a_tvalid,
    input  logic              fmul_axis_a_tready,
    output logic [DATA_W-1:0] fmul_axis_b_tdata,
    output logic              fmul_axis_b_tvalid,
    input  logic              fmul_axis_b_tready,
    input  logic [DATA_W-1:0] fmul_axis_result_tdata,
    input  logic              fmul_axis_result_tvalid,
    output logic              fmul_axis_result_tready,
    output logic [DATA_W-1:0] fdiv_axis_a_tdata,
    output logic              fdiv_axis_a_tvalid,
    input  logic              fdiv_axis_a_tready,
    output logic [DATA_W-1:0] fdiv_axis_b_tdata,
    output logic              fdiv_axis_b_tvalid,
    input  logic              fdiv_axis_b_tready,
    input  logic [DATA_W-1:0] fdiv_axis_result_tdata,
    input  logic              fdiv_axis_result_tvalid,
    output logic              fdiv_axis_result_tready
);

    logic [NUM_UNITS-1:0] accept_v, grant_v, idle_v, done_v;
    logic [NUM_UNITS-1:0] a_tvalid_v, a_tready_v, b_tvalid_v, b_tready_v;
    logic [NUM_UNITS-1:0] r_tvalid_v, r_tready_v;
    logic [DATA_W-1:0]    a_tdata_v [NUM_UNITS];
    logic [DATA_W-1:0]    b_tdata_v [NUM_UNITS];
    logic [DATA_W-1:0]    r_tdata_v [NUM_UNITS];
    logic [DATA_W-1:0]    buf_v     [NUM_UNITS];
    logic [TAG_W-1:0]     rd_v      [NUM_UNITS];
    slot_state_t          st_v      [NUM_UNITS];

    logic                 accept;
    logic                 load_en;
    logic                 any_done;
    logic [1:0]           gsel;
    logic [1:0]           rr_ptr;
    logic [31:0]          pending_nxt;

    // Pack the per-unit AXIS ports so the slots can be generated.
    assign a_tready_v = {fdiv_axis_a_tready, fmul_axis_a_tready,
                         fsub_axis_a_tready, fadd_axis_a_tready};
    assign b_tready_v = {fdiv_axis_b_tready, fmul_axis_b_tready,
                         fsub_axis_b_tready, fadd_axis_b_tready};
    assign r_tvalid_v = {fdiv_axis_result_tvalid, fmul_axis_result_tvalid,
                         fsub_axis_result_tvalid, fadd_axis_result_tvalid};
    assign r_tdata_v[FADD] = fadd_axis_result_tdata;
    assign r_tdata_v[FSUB] = fsub_axis_result_tdata;
    assign r_tdata_v[FMUL] = fmul_axis_result_tdata;
    assign r_tdata_v[FDIV] = fdiv_axis_result_tdata;

    assign fadd_axis_a_tdata       = a_tdata_v[FADD];
    assign fadd_axis_a_tvalid      = a_tvalid_v[FADD];
    assign fadd_axis_b_tdata       = b_tdata_v[FADD];
    assign fadd_axis_b_tvalid      = b_tvalid_v[FADD];
    assign fadd_axis_result_tready = r_tready_v[FADD];
    assign fsub_axis_a_tdata       = a_tdata_v[FSUB];
    assign fsub_axis_a_tvalid      = a_tvalid_v[FSUB];
    assign fsub_axis_b_tdata       = b_tdata_v[FSUB];
    assign fsub_axis_b_tvalid      = b_tvalid_v[FSUB];
    assign fsub_axis_result_tready = r_tready_v[FSUB];
    assign fmul_axis_a_tdata       = a_tdata_v[FMUL];
    assign fmul_axis_a_tvalid      = a_tvalid_v[FMUL];
    assign fmul_axis_b_tdata       = b_tdata_v[FMUL];
    assign fmul_axis_b_tvalid      = b_tvalid_v[FMUL];
    assign fmul_axis_result_tready = r_tready_v[FMUL];
    assign fdiv_axis_a_tdata       = a_tdata_v[FDIV];
    assign fdiv_axis_a_tvalid      = a_tvalid_v[FDIV];
    assign fdiv_axis_b_tdata       = b_tdata_v[FDIV];
    assign fdiv_axis_b_tvalid      = b_tvalid_v[FDIV];
    assign fdiv_axis_result_tready = r_tready_v[FDIV];

    // Request decode: registered state only, independent of req_valid.
    assign req_ready = idle_v[req_op] && !pending[req_rd];
    assign accept    = req_valid && req_ready;
    assign accept_v  = accept ? (NUM_UNITS'(1) << req_op) : '0;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
        fpu_slot #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_slot (
            .clk                (clk),
            .rstn               (rstn),
            .accept             (accept_v[u]),
            .op_a               (req_a),
            .op_b               (req_b),
            .op_rd              (req_rd),
            .grant              (grant_v[u]),
            .state              (st_v[u]),
            .slot_rd            (rd_v[u]),
            .slot_result        (buf_v[u]),
            .axis_a_tdata       (a_tdata_v[u]),
            .axis_a_tvalid      (a_tvalid_v[u]),
            .axis_a_tready      (a_tready_v[u]),
            .axis_b_tdata       (b_tdata_v[u]),
            .axis_b_tvalid      (b_tvalid_v[u]),
            .axis_b_tready      (b_tready_v[u]),
            .axis_result_tdata  (r_tdata_v[u]),
            .axis_result_tvalid (r_tvalid_v[u]),
            .axis_result_tready (r_tready_v[u])
        );
        assign idle_v[u] = (st_v[u] == IDLE);
        assign done_v[u] = (st_v[u] == DONE);
    end

    // Output arbiter: the register reloads when empty or being drained,
    // so back-to-back results flow without a bubble.
    assign load_en  = !res_valid || res_ready;
    assign any_done = |done_v;
    assign gsel     = rr_pick(done_v, rr_ptr);
    assign grant_v  = (load_en && any_done) ? (NUM_UNITS'(1) << gsel) : '0;

    // Clear before set: a request for res_rd cannot be accepted in the
    // handoff cycle because req_ready still sees the old pending bit.
    always_comb begin
        pending_nxt = pending;
        if (res_valid && res_ready) pending_nxt[res_rd] = 1'b0;
        if (accept)                 pending_nxt[req_rd] = 1'b1;
    end

    // ---- output register / scoreboard ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            rr_ptr    <= FADD;
            pending   <= '0;
        end else begin
            pending <= pending_nxt;
            if (load_en) begin
                res_valid <= any_done;
                if (any_done) begin
                    res_data <= buf_v[gsel];
                    res_rd   <= rd_v[gsel];
                    rr_ptr   <= gsel + 2'd1;
                end
            end
        end
    end

endmodule
